// File: rtl/cipher_pkg.sv
// Shared types for the cipher output path: one byte plus its end-of-burst tag.
package cipher_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } cbyte_t;

endpackage

// File: rtl/cipher_byte_fifo.sv
// Register-array FIFO of tagged cipher bytes with wrap-bit pointers and a registered level.
module cipher_byte_fifo
  import cipher_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  cbyte_t           push_data_i,
  input  logic             pop_i,
  output cbyte_t           head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             push_ok_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int unsigned AW = LVL_W - 1;

  cbyte_t           mem_q [DEPTH];
  logic [LVL_W-1:0] wr_q, wr_d;
  logic [LVL_W-1:0] rd_q, rd_d;
  logic [LVL_W-1:0] level_q;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok    = pop_i && !empty_o;
  assign push_ok_o = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok_o) wr_d = wr_q + LVL_W'(1);
    if (pop_ok)    rd_d = rd_q + LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= wr_d - rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  assign level_o = level_q;

endmodule

// File: rtl/cipher_out_framer.sv
// Captures cipher output bytes, tags the last byte of each burst and queues them
// behind a valid/ready interface with a sticky overflow flag.
module cipher_out_framer
  import cipher_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_ready,
  input  logic [BYTE_W-1:0] din_char,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clr
);

  logic              hold_v_q, hold_v_d;
  logic [BYTE_W-1:0] hold_d_q, hold_d_d;
  logic              ovf_q, ovf_d;

  cbyte_t push_data;
  cbyte_t head;
  logic   push, push_ok, pop, drop;
  logic   fifo_empty, fifo_full;

  // The held byte is pushed one cycle late, so its tag is known: a gap ends the burst.
  assign push      = hold_v_q;
  assign push_data = '{last: !din_ready, data: hold_d_q};
  assign pop       = m_valid && m_ready;
  assign drop      = push && !push_ok;

  always_comb begin
    hold_v_d = din_ready;
    hold_d_d = din_ready ? din_char : hold_d_q;
    ovf_d    = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q <= 1'b0;
      hold_d_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_d_q <= hold_d_d;
      ovf_q    <= ovf_d;
    end
  end

  cipher_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .push_ok_o   (push_ok),
    .level_o     (level)
  );

  assign m_valid  = !fifo_empty;
  assign m_data   = head.data;
  assign m_last   = head.last;
  assign full     = fifo_full;
  assign overflow = ovf_q;

endmodule
